// File: rtl/sha256_block_padder_if.sv
// Word-in / block-out stream bundle for the SHA-256 padder.
// The master side feeds words and consumes blocks; the slave side is the padder.
interface sha256_block_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic [7:0]   blk_index;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last, blk_index
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, blk_index
  );
endinterface

// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and appends
// the 0x80000000 marker, zero fill and 64-bit big-endian bit length.
//
// state | meaning
// FILL  | accepting message words into the block buffer
// PAD   | one cycle: write marker / zeros / length after the last word
// EMIT  | block presented downstream, waiting for blk_ready
// EXTRA | one cycle: build the trailing length-only block
module sha256_block_padder #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  sha256_block_padder_if.slave bus
);

  localparam int LEN_PAD_W = 64 - CNT_W - 5;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    EMIT  = 2'd2,
    EXTRA = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        blk_buf [16];
  logic [3:0]         idx;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         blk_idx;
  logic               last_q;
  logic               extra_q;
  logic               marker_q;
  logic [63:0]        bit_len;
  logic               in_fire;
  logic               blk_fire;

  assign bit_len  = {{LEN_PAD_W{1'b0}}, cnt, 5'b0};
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign blk_fire = bus.blk_valid && bus.blk_ready;

  assign bus.in_ready  = (state == FILL);
  assign bus.blk_valid = (state == EMIT);
  assign bus.blk_last  = last_q && (state == EMIT);
  assign bus.blk_index = blk_idx;

  for (genvar k = 0; k < 16; k++) begin : g_blk_data
    assign bus.blk_data[511-32*k -: 32] = blk_buf[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (in_fire) begin
          if (bus.in_last) begin
            state_nxt = PAD;
          end else if (idx == 4'd15) begin
            state_nxt = EMIT;
          end
        end
      end
      PAD: begin
        state_nxt = EMIT;
      end
      EMIT: begin
        if (blk_fire) begin
          state_nxt = extra_q ? EXTRA : FILL;
        end
      end
      EXTRA: begin
        state_nxt = EMIT;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // After in_last, idx is left pointing at the final word (j) so PAD can place
  // the marker relative to it; it is cleared once the message's last block goes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        blk_buf[i] <= 32'h0;
      end
      idx      <= 4'd0;
      cnt      <= '0;
      blk_idx  <= 8'd0;
      last_q   <= 1'b0;
      extra_q  <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            blk_buf[idx] <= bus.in_data;
            cnt          <= cnt + 1'b1;
            last_q       <= 1'b0;
            if (!bus.in_last) begin
              idx <= idx + 4'd1;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (i == int'(idx) + 1) begin
              blk_buf[i] <= 32'h8000_0000;
            end else if (i > int'(idx) + 1) begin
              if (idx <= 4'd12 && i == 14) begin
                blk_buf[i] <= bit_len[63:32];
              end else if (idx <= 4'd12 && i == 15) begin
                blk_buf[i] <= bit_len[31:0];
              end else begin
                blk_buf[i] <= 32'h0;
              end
            end
          end
          last_q   <= (idx <= 4'd12);
          extra_q  <= (idx > 4'd12);
          marker_q <= (idx == 4'd15);
        end
        EMIT: begin
          if (blk_fire) begin
            blk_idx <= blk_idx + 8'd1;
            if (!extra_q && last_q) begin
              idx     <= 4'd0;
              cnt     <= '0;
              blk_idx <= 8'd0;
            end
          end
        end
        EXTRA: begin
          for (int i = 0; i < 14; i++) begin
            blk_buf[i] <= 32'h0;
          end
          if (marker_q) begin
            blk_buf[0] <= 32'h8000_0000;
          end
          blk_buf[14] <= bit_len[63:32];
          blk_buf[15] <= bit_len[31:0];
          extra_q     <= 1'b0;
          marker_q    <= 1'b0;
          last_q      <= 1'b1;
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Self-checking bench for sha256_block_padder: directed padding cases, latency,
// backpressure, reset abort and randomized messages against a padding model.
module tb_sha256_block_padder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sha256_block_padder_if pif ();

  sha256_block_padder #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  msg [$];
  logic [511:0] exp_data [$];
  logic         exp_last [$];
  logic [7:0]   exp_idx [$];
  logic [511:0] rx_data [$];
  logic         rx_last [$];
  logic [7:0]   rx_idx [$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [511:0] blk, input int k);
    return blk[511-32*k -: 32];
  endfunction

  // Padded message = words, marker, zeros up to 14 mod 16, 64-bit bit length.
  task automatic build_model();
    logic [31:0]  p [$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nblk;
    exp_data.delete();
    exp_last.delete();
    exp_idx.delete();
    p = msg;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    bits = 64'(msg.size()) * 64'd32;
    p.push_back(bits[63:32]);
    p.push_back(bits[31:0]);
    nblk = p.size() / 16;
    for (int n = 0; n < nblk; n++) begin
      for (int k = 0; k < 16; k++) b[511-32*k -: 32] = p[16*n+k];
      exp_data.push_back(b);
      exp_last.push_back(n == nblk - 1);
      exp_idx.push_back(8'(n));
    end
  endtask

  task automatic send_words(input bit mark_last, input int gap_max);
    int cyc;
    for (int i = 0; i < msg.size(); i++) begin
      pif.in_valid = 1'b0;
      pif.in_last  = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      pif.in_valid = 1'b1;
      pif.in_data  = msg[i];
      pif.in_last  = mark_last && (i == msg.size() - 1);
      cyc = 0;
      while (!pif.in_ready && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk("in_ready_wait", 512'(pif.in_ready), 512'(1));
      @(negedge clk);
    end
    pif.in_valid = 1'b0;
    pif.in_last  = 1'b0;
  endtask

  task automatic recv_blocks(input int n, input int pct);
    int           got = 0;
    int           cyc = 0;
    logic         held_v = 1'b0;
    logic         held_r = 1'b0;
    logic [511:0] hd = '0;
    logic         hl = 1'b0;
    logic [7:0]   hi = 8'd0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (held_v && !held_r) begin
        chk("hold_valid", 512'(pif.blk_valid), 512'(1));
        chk("hold_data", pif.blk_data, hd);
        chk("hold_last", 512'(pif.blk_last), 512'(hl));
        chk("hold_index", 512'(pif.blk_index), 512'(hi));
        chk("hold_in_ready", 512'(pif.in_ready), 512'(0));
      end
      pif.blk_ready = (int'($urandom_range(99, 0)) < pct);
      hd     = pif.blk_data;
      hl     = pif.blk_last;
      hi     = pif.blk_index;
      held_v = pif.blk_valid;
      held_r = pif.blk_ready;
      if (pif.blk_valid && pif.blk_ready) begin
        rx_data.push_back(pif.blk_data);
        rx_last.push_back(pif.blk_last);
        rx_idx.push_back(pif.blk_index);
        got++;
      end
    end
    @(negedge clk);
    pif.blk_ready = 1'b0;
    chk("rx_count", 512'(got), 512'(n));
  endtask

  task automatic run_msg(input int pct, input int gap_max);
    build_model();
    rx_data.delete();
    rx_last.delete();
    rx_idx.delete();
    fork
      send_words(1'b1, gap_max);
      recv_blocks(exp_data.size(), pct);
    join
    for (int b = 0; b < exp_data.size() && b < rx_data.size(); b++) begin
      chk($sformatf("blk%0d_data", b), rx_data[b], exp_data[b]);
      chk($sformatf("blk%0d_last", b), 512'(rx_last[b]), 512'(exp_last[b]));
      chk($sformatf("blk%0d_index", b), 512'(rx_idx[b]), 512'(exp_idx[b]));
    end
  endtask

  task automatic count_msg(input int len);
    msg.delete();
    for (int i = 1; i <= len; i++) msg.push_back(32'(i));
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: no finish within cycle budget");
    $fatal(1);
  end

  initial begin
    int           lens [5];
    int           cyc;
    int           len;
    logic [511:0] hd;
    logic         hl;
    logic [7:0]   hi;

    pif.in_valid  = 1'b0;
    pif.in_data   = 32'h0;
    pif.in_last   = 1'b0;
    pif.blk_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 512'(pif.in_ready), 512'(1));
    chk("rst_blk_valid", 512'(pif.blk_valid), 512'(0));
    chk("rst_blk_last", 512'(pif.blk_last), 512'(0));
    chk("rst_blk_index", 512'(pif.blk_index), 512'(0));

    // Single word: PAD bubble then block two cycles after the accept edge.
    msg.delete();
    msg.push_back(32'h6162_6364);
    build_model();
    pif.in_valid = 1'b1;
    pif.in_data  = msg[0];
    pif.in_last  = 1'b1;
    chk("t1_in_ready", 512'(pif.in_ready), 512'(1));
    @(negedge clk);
    pif.in_valid = 1'b0;
    pif.in_last  = 1'b0;
    chk("t1_pad_valid", 512'(pif.blk_valid), 512'(0));
    chk("t1_pad_in_ready", 512'(pif.in_ready), 512'(0));
    @(negedge clk);
    chk("t1_emit_valid", 512'(pif.blk_valid), 512'(1));
    chk("t1_data", pif.blk_data, exp_data[0]);
    chk("t1_w1", 512'(word_of(pif.blk_data, 1)), 512'(32'h8000_0000));
    chk("t1_w15", 512'(word_of(pif.blk_data, 15)), 512'(32'h20));
    chk("t1_last", 512'(pif.blk_last), 512'(1));
    chk("t1_index", 512'(pif.blk_index), 512'(0));
    pif.blk_ready = 1'b1;
    @(negedge clk);
    pif.blk_ready = 1'b0;
    chk("t1_done_valid", 512'(pif.blk_valid), 512'(0));
    chk("t1_done_in_ready", 512'(pif.in_ready), 512'(1));

    // Boundary lengths around the marker/length split.
    lens = '{20, 14, 16, 13, 15};
    foreach (lens[t]) begin
      count_msg(lens[t]);
      run_msg(100, 0);
      case (lens[t])
        20: begin
          chk("l20_b1_w4", 512'(word_of(rx_data[1], 4)), 512'(32'h8000_0000));
          chk("l20_b1_w15", 512'(word_of(rx_data[1], 15)), 512'(32'h280));
        end
        14: begin
          chk("l14_b0_w14", 512'(word_of(rx_data[0], 14)), 512'(32'h8000_0000));
          chk("l14_b1_w15", 512'(word_of(rx_data[1], 15)), 512'(32'h1C0));
        end
        16: begin
          chk("l16_b1_w0", 512'(word_of(rx_data[1], 0)), 512'(32'h8000_0000));
          chk("l16_b1_w15", 512'(word_of(rx_data[1], 15)), 512'(32'h200));
          chk("l16_b1_index", 512'(rx_idx[1]), 512'(1));
        end
        default: ;
      endcase
    end

    // Backpressure on a 14-word message, then the extra-block bubble.
    msg.delete();
    for (int i = 0; i < 14; i++) msg.push_back($urandom);
    build_model();
    send_words(1'b1, 0);
    cyc = 0;
    while (!pif.blk_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_valid", 512'(pif.blk_valid), 512'(1));
    hd = pif.blk_data;
    hl = pif.blk_last;
    hi = pif.blk_index;
    chk("bp_b0_data", hd, exp_data[0]);
    chk("bp_b0_last", 512'(hl), 512'(0));
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable_valid", 512'(pif.blk_valid), 512'(1));
      chk("bp_stable_data", pif.blk_data, hd);
      chk("bp_stable_last", 512'(pif.blk_last), 512'(hl));
      chk("bp_stable_index", 512'(pif.blk_index), 512'(hi));
      chk("bp_in_ready", 512'(pif.in_ready), 512'(0));
    end
    pif.blk_ready = 1'b1;
    @(negedge clk);
    pif.blk_ready = 1'b0;
    chk("bp_extra_valid", 512'(pif.blk_valid), 512'(0));
    chk("bp_extra_in_ready", 512'(pif.in_ready), 512'(0));
    @(negedge clk);
    chk("bp_b1_valid", 512'(pif.blk_valid), 512'(1));
    chk("bp_b1_data", pif.blk_data, exp_data[1]);
    chk("bp_b1_last", 512'(pif.blk_last), 512'(1));
    chk("bp_b1_index", 512'(pif.blk_index), 512'(1));
    pif.blk_ready = 1'b1;
    @(negedge clk);
    pif.blk_ready = 1'b0;
    chk("bp_done_in_ready", 512'(pif.in_ready), 512'(1));
    chk("bp_done_valid", 512'(pif.blk_valid), 512'(0));
    chk("bp_done_index", 512'(pif.blk_index), 512'(0));

    // Reset after 7 words of a 20-word message discards it.
    count_msg(7);
    send_words(1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", 512'(pif.in_ready), 512'(1));
    chk("abort_blk_valid", 512'(pif.blk_valid), 512'(0));
    msg.delete();
    msg.push_back(32'hDEAD_BEEF);
    run_msg(100, 0);
    chk("abort_w0", 512'(word_of(rx_data[0], 0)), 512'(32'hDEAD_BEEF));
    chk("abort_w1", 512'(word_of(rx_data[0], 1)), 512'(32'h8000_0000));
    chk("abort_w15", 512'(word_of(rx_data[0], 15)), 512'(32'h20));

    // Random messages, lengths biased toward the 13..16 mod 16 boundaries.
    for (int m = 0; m < 40; m++) begin
      if (m % 3 == 0) begin
        len = 13 + int'($urandom_range(3, 0)) + 16 * int'($urandom_range(1, 0));
      end else begin
        len = int'($urandom_range(40, 1));
      end
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back($urandom);
      run_msg(int'($urandom_range(100, 30)), int'($urandom_range(2, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha256_block_padder.md
Name: sha256_block_padder

Overview:
- Streaming front-end for the SHA-256 compression engine.
- Accepts a message as 32-bit words over a valid/ready handshake and applies SHA-256 padding: a 0x80000000 marker word, zero fill, and a 64-bit big-endian bit length.
- Emits 512-bit blocks over a valid/ready handshake. blk_last marks the final block of each message.
- Sits directly upstream of the hash engine and replaces its in-engine padding logic.

Parameters:
- CNT_W, default 32: width of the message word counter. Messages of 2^CNT_W words or more are unsupported; the counter wraps.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word this cycle.
- in_data, input, 32: message word, big-endian word order.
- in_last, input, 1: qualifies the final word of a message. Every message contains at least 1 word.
- blk_valid, output, 1: blk_data is valid.
- blk_ready, input, 1: downstream accepts the block.
- blk_data, output, 512: block contents. Word 0 is on [511:480] and word 15 is on [31:0].
- blk_last, output, 1: final block of the message; qualified by blk_valid.
- blk_index, output, 8: block number within the current message, starting at 0; qualified by blk_valid.

Behaviour:
- Reset (synchronous; takes effect at the first rising edge with reset=1):
  - state=FILL, word index=0, word count=0, buffer cleared.
  - in_ready=1 once state=FILL; blk_valid=0, blk_last=0, blk_index=0.
  - Reset mid-message or mid-block discards all partial data. No block is emitted for the discarded message.
- Handshakes:
  - A transfer occurs on any edge where valid and ready are both 1.
  - in_ready = (state==FILL).
  - blk_valid = (state==EMIT).
  - blk_data, blk_last and blk_index are held stable while blk_valid=1 and blk_ready=0.
  - blk_ready is ignored when blk_valid=0.
- States:
  - FILL: each accepted word is written to buffer[idx]; idx and word count increment.
    - If in_last=0 and idx==15: go to EMIT with last=0, then idx=0.
    - If in_last=1 (last word stored at index j): go to PAD.
  - PAD: one cycle; in_ready=0.
    - j<=12: buffer[j+1]=0x80000000, buffer[j+2..13]=0, buffer[14..15]=bit length. Go to EMIT with last=1.
    - j==13 or j==14: buffer[j+1]=0x80000000, zeros to index 15. Go to EMIT with last=0 and set extra=1.
    - j==15: no buffer change. Go to EMIT with last=0 and set extra=1, marker pending.
  - EMIT: on blk_ready, blk_index increments.
    - extra=1: go to EXTRA.
    - Otherwise, if last=1: return to FILL with idx=0, count=0, blk_index=0.
    - Otherwise (full data block): return to FILL.
  - EXTRA: one cycle; builds an all-zero buffer.
    - Word 0 = 0x80000000 if the marker is pending, else 0.
    - Words 14..15 = bit length.
    - Clear extra. Go to EMIT with last=1.
- Bit length:
  - 64-bit value = word count × 32, computed as {zero-extend(count), 5'b0}.
  - Word 14 holds the upper 32 bits and word 15 the lower 32 bits.
- Latency:
  - 16th non-last word accepted at edge t: blk_valid=1 in the cycle after t.
  - Last word accepted at edge t: blk_valid=1 after edge t+1 (PAD).
  - Extra block: blk_valid=1 after the edge that follows the first block's handshake (1 bubble cycle).
- Throughput: one word per cycle during FILL. The input stalls during PAD, EMIT and EXTRA.
- The output buffer is single; no new input is accepted until the current block transfers.

Test Plan:
- Single message word 0x61626364 with in_last=1 → one block:
  - w0=0x61626364, w1=0x80000000, w2..w14=0, w15=0x00000020.
  - blk_last=1, blk_index=0.
  - blk_valid rises 2 cycles after the accept edge.
- 20 words with values 1..20:
  - Block 0: w0..w15 = 1..16, last=0, index 0.
  - Block 1: w0..w3 = 17..20, w4=0x80000000, w14=0, w15=0x00000280, last=1, index 1.
- 14 words (j=13):
  - Block 0: w14=0x80000000, w15=0, last=0.
  - Block 1: all zero except w15=0x000001C0, last=1.
- 16 words (j=15):
  - Block 0: data only, last=0.
  - Block 1: w0=0x80000000, w15=0x00000200, last=1, index 1.
- Backpressure: hold blk_ready=0 for 5 cycles with blk_valid=1 → blk_data/blk_last/blk_index stable and in_ready=0 throughout. Raise blk_ready → exactly one transfer, then in_ready=1 (or EXTRA).
- Assert reset after 7 of 20 words → next cycle in_ready=1, blk_valid=0. A subsequent 1-word message 0xDEADBEEF yields w15=0x20, with no residue from the aborted message.
